pipeline_sequencer: RTL
=======================

// Module: pipeline_sequencer
// PURPOSE
//  Central sequencing for the 5-stage 19-bit-instruction pipeline: decides PC source, PC/IF-ID write
//  enables, IF/ID flush and ID/EX bubble each cycle from the ID-stage decode, EX-stage hazard info,
//  the C/Z flags and stack status. Replaces ad-hoc hazard muxing; sits beside Controller in stage 1.
// PARAMETERS
//  REG_ID_LEN  3   register-id width (rs/rt/rd)
//  CNT_WIDTH   16  width of saturating stall/flush event counters
// PORTS
//  clk            in   1   clock; all state updates on rising edge
//  rst            in   1   asynchronous, active-low reset
//  id_valid       in   1   IF/ID holds a real instruction
//  id_branch      in   1   conditional branch in ID (target = PC+1+offset)
//  id_cond        in   2   branch condition: 00 Z, 01 !Z, 10 C, 11 !C
//  id_jump        in   1   absolute jump in ID (target = instr[11:0])
//  id_call        in   1   call in ID (absolute target, push PC+1)
//  id_ret         in   1   return in ID (target = stack top, pop)
//  id_uses_rs     in   1   ID instruction reads rs
//  id_uses_rt     in   1   ID instruction reads rt
//  id_rs, id_rt   in   REG_ID_LEN  ID source register ids
//  ex_mem_read    in   1   instruction in EX is a load
//  ex_rd          in   REG_ID_LEN  destination of EX instruction
//  ex_flag_write  in   1   EX instruction updates C/Z this cycle
//  c_flag, z_flag in   1   registered C and Z
//  stack_full     in   1   return stack cannot accept push
//  stack_empty    in   1   return stack has no entry
//  pc_write_en    out  1   PC register load enable
//  if_id_write_en out  1   IF/ID load enable
//  if_id_flush    out  1   clear IF/ID (valid=0) at next edge
//  id_ex_bubble   out  1   force ID/EX write-enables (RF, MEM, flags) to 0
//  pc_sel         out  2   00 PC+1, 01 const, 10 PC+offset, 11 stack
//  push_stack     out  1   one-cycle push of PC+1
//  pop_stack      out  1   one-cycle pop
//  seq_fault      out  1   sticky stack overflow/underflow flag
//  stall_count    out  CNT_WIDTH  stall cycles since reset (saturating)
//  flush_count    out  CNT_WIDTH  redirects since reset (saturating)
// BEHAVIOUR
//  States: S_INIT, S_RUN, S_LSTALL, S_FWAIT, S_REDIR, S_FAULT. rst low -> S_INIT, counters 0,
//  seq_fault 0. S_INIT (and rst low): pc_write_en=0, if_id_write_en=0, if_id_flush=1, id_ex_bubble=1,
//  pc_sel=00, push/pop=0. S_INIT -> S_RUN unconditionally.
//  Default outputs (S_RUN, S_REDIR, S_LSTALL, S_FWAIT): enables 1, flush 0, bubble 0, pc_sel 00, push/pop 0.
//  S_RUN, id_valid=1, priority high->low:
//   1 load-use: ex_mem_read & ((id_uses_rs & rs==ex_rd) | (id_uses_rt & rt==ex_rd)) -> pc_write_en=0,
//     if_id_write_en=0, bubble=1; -> S_LSTALL.
//   2 id_branch & ex_flag_write -> same stall outputs; -> S_FWAIT.
//   3 (id_call & stack_full) | (id_ret & stack_empty) -> S_FAULT, no push/pop.
//   4 redirect: taken branch (cond true on c/z) ->10; jump ->01; call ->01+push; ret ->11+pop;
//     if_id_flush=1; -> S_REDIR. Untaken branch: no action, stays S_RUN.
//  S_LSTALL / S_FWAIT: one cycle only; hazard checks 1-2 masked, rules 3-4 evaluated as in S_RUN
//  (may go to S_REDIR/S_FAULT), else -> S_RUN.
//  S_REDIR: id controls ignored (wrong-path slot), no redirect/push/pop; -> S_RUN.
//  S_FAULT: pc_write_en=0, if_id_write_en=0, bubble=1, seq_fault=1; exit only via rst.
//  Counters: stall_count +1 on every cycle with pc_write_en=0 in S_RUN/S_LSTALL/S_FWAIT-entry
//  (i.e. each cycle stall outputs asserted outside S_INIT/S_FAULT); flush_count +1 per if_id_flush
//  outside S_INIT. Both saturate at all-ones.
//  id_valid=0 -> defaults, no state change except S_REDIR/S_LSTALL/S_FWAIT -> S_RUN.
//  Only one of push_stack/pop_stack ever asserted; each at most one cycle per instruction.
// STRUCTURE
//  pipe_seq_pkg: state enum, PC_SEL_* constants, COND_* encoding.
//  Sub-module load_use_detect (combinational compare of rs/rt vs ex_rd); FSM + counters in top.
// TESTING
//  lw r1 in EX, add r2,r1,r3 in ID -> 1 cycle pc_write_en=0, bubble=1, stall_count=1, then normal.
//  BZ in ID, EX cmp sets flags, z becomes 1 -> 1-cycle S_FWAIT, then pc_sel=10, flush=1, flush_count=1.
//  BNZ with z_flag=1, ex_flag_write=0 -> not taken, pc_sel=00, no flush.
//  call with stack_full=0 -> pc_sel=01, push_stack=1 one cycle; ret next -> pc_sel=11, pop_stack=1.
//  ret with stack_empty=1 -> seq_fault=1, PC frozen for 10 cycles; rst low -> S_INIT, fault 0.
//  rst asserted mid-stall (S_LSTALL) -> outputs at S_INIT values immediately, counters 0, S_RUN after release.

Source files
------------

// File: rtl/pipe_seq_pkg.sv
// Shared types and encodings for the pipeline sequencer: FSM states,
// PC source select codes and branch condition codes.
package pipe_seq_pkg;

    typedef enum logic [2:0] {
        S_INIT   = 3'd0,
        S_RUN    = 3'd1,
        S_LSTALL = 3'd2,
        S_FWAIT  = 3'd3,
        S_REDIR  = 3'd4,
        S_FAULT  = 3'd5
    } seq_state_t;

    localparam logic [1:0] PC_SEL_INC    = 2'b00;
    localparam logic [1:0] PC_SEL_CONST  = 2'b01;
    localparam logic [1:0] PC_SEL_OFFSET = 2'b10;
    localparam logic [1:0] PC_SEL_STACK  = 2'b11;

    localparam logic [1:0] COND_Z  = 2'b00;
    localparam logic [1:0] COND_NZ = 2'b01;
    localparam logic [1:0] COND_C  = 2'b10;
    localparam logic [1:0] COND_NC = 2'b11;

    function automatic logic cond_true(input logic [1:0] cond, input logic c, input logic z);
        case (cond)
            COND_Z:  return z;
            COND_NZ: return !z;
            COND_C:  return c;
            default: return !c;
        endcase
    endfunction

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detect: the ID instruction reads a register
// that the load currently in EX has not yet produced.
module load_use_detect #(
    parameter int REG_ID_LEN = 3
) (
    input  logic                  ex_mem_read,
    input  logic                  uses_rs,
    input  logic                  uses_rt,
    input  logic [REG_ID_LEN-1:0] rs,
    input  logic [REG_ID_LEN-1:0] rt,
    input  logic [REG_ID_LEN-1:0] ex_rd,
    output logic                  hazard
);

    assign hazard = ex_mem_read && ((uses_rs && (rs == ex_rd)) || (uses_rt && (rt == ex_rd)));

endmodule

// File: rtl/pipeline_sequencer.sv
// Central pipeline sequencer: picks the PC source, stalls on load-use and
// pending-flag branches, flushes on redirects and traps on stack misuse.
module pipeline_sequencer
    import pipe_seq_pkg::*;
#(
    parameter int REG_ID_LEN = 3,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic                  id_branch,
    input  logic [1:0]            id_cond,
    input  logic                  id_jump,
    input  logic                  id_call,
    input  logic                  id_ret,
    input  logic                  id_uses_rs,
    input  logic                  id_uses_rt,
    input  logic [REG_ID_LEN-1:0] id_rs,
    input  logic [REG_ID_LEN-1:0] id_rt,
    input  logic                  ex_mem_read,
    input  logic [REG_ID_LEN-1:0] ex_rd,
    input  logic                  ex_flag_write,
    input  logic                  c_flag,
    input  logic                  z_flag,
    input  logic                  stack_full,
    input  logic                  stack_empty,
    output logic                  pc_write_en,
    output logic                  if_id_write_en,
    output logic                  if_id_flush,
    output logic                  id_ex_bubble,
    output logic [1:0]            pc_sel,
    output logic                  push_stack,
    output logic                  pop_stack,
    output logic                  seq_fault,
    output logic [CNT_WIDTH-1:0]  stall_count,
    output logic [CNT_WIDTH-1:0]  flush_count
);

    seq_state_t state, next_state;

    logic load_use;
    logic decide;
    logic stall_hz;
    logic stack_err;
    logic taken;
    logic redirect;

    load_use_detect #(.REG_ID_LEN(REG_ID_LEN)) u_load_use_detect (
        .ex_mem_read (ex_mem_read),
        .uses_rs     (id_uses_rs),
        .uses_rt     (id_uses_rt),
        .rs          (id_rs),
        .rt          (id_rt),
        .ex_rd       (ex_rd),
        .hazard      (load_use)
    );

    // A stall state lasts exactly one cycle, so hazard checks only run from S_RUN.
    assign decide    = id_valid && (state inside {S_RUN, S_LSTALL, S_FWAIT});
    assign stall_hz  = id_valid && (state == S_RUN) && (load_use || (id_branch && ex_flag_write));
    assign stack_err = (id_call && stack_full) || (id_ret && stack_empty);
    assign taken     = id_branch && cond_true(id_cond, c_flag, z_flag);
    assign redirect  = taken || id_jump || id_call || id_ret;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_INIT;
        else      state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_INIT:  next_state = S_RUN;
            S_REDIR: next_state = S_RUN;
            S_FAULT: next_state = S_FAULT;
            default: begin
                next_state = S_RUN;
                if (stall_hz)
                    next_state = load_use ? S_LSTALL : S_FWAIT;
                else if (decide && stack_err)
                    next_state = S_FAULT;
                else if (decide && redirect)
                    next_state = S_REDIR;
            end
        endcase
    end

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        pc_write_en    = 1'b1;
        if_id_write_en = 1'b1;
        if_id_flush    = 1'b0;
        id_ex_bubble   = 1'b0;
        pc_sel         = PC_SEL_INC;
        push_stack     = 1'b0;
        pop_stack      = 1'b0;
        seq_fault      = 1'b0;
        case (state)
            S_INIT: begin
                pc_write_en    = 1'b0;
                if_id_write_en = 1'b0;
                if_id_flush    = 1'b1;
                id_ex_bubble   = 1'b1;
            end
            S_FAULT: begin
                pc_write_en    = 1'b0;
                if_id_write_en = 1'b0;
                id_ex_bubble   = 1'b1;
                seq_fault      = 1'b1;
            end
            S_REDIR: ;
            default: begin
                if (stall_hz) begin
                    pc_write_en    = 1'b0;
                    if_id_write_en = 1'b0;
                    id_ex_bubble   = 1'b1;
                end else if (decide && !stack_err && redirect) begin
                    if_id_flush = 1'b1;
                    if (taken) begin
                        pc_sel = PC_SEL_OFFSET;
                    end else if (id_jump) begin
                        pc_sel = PC_SEL_CONST;
                    end else if (id_call) begin
                        pc_sel     = PC_SEL_CONST;
                        push_stack = 1'b1;
                    end else begin
                        pc_sel    = PC_SEL_STACK;
                        pop_stack = 1'b1;
                    end
                end
            end
        endcase
    end

    logic stall_inc;
    logic flush_inc;

    assign stall_inc = !pc_write_en && (state inside {S_RUN, S_LSTALL, S_FWAIT});
    assign flush_inc = if_id_flush && (state != S_INIT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (stall_inc && (stall_count != '1)) stall_count <= stall_count + 1'b1;
            if (flush_inc && (flush_count != '1)) flush_count <= flush_count + 1'b1;
        end
    end

endmodule
